// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks the register file through its third read port and
// streams a sync byte plus all 32 words (MSB first) over an 8N1 UART line.
module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  dump_reg,
    input  logic [31:0] dump_dat,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_MAX = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [31:0]   snap_q, snap_d;
    logic [4:0]    reg_idx_q, reg_idx_d;
    logic [4:0]    dump_reg_q, dump_reg_d;
    logic [1:0]    byte_q, byte_d;
    logic          hdr_q, hdr_d;
    logic          frame_end;
    logic [7:0]    nxt_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            snap_q     <= '0;
            reg_idx_q  <= '0;
            dump_reg_q <= '0;
            byte_q     <= '0;
            hdr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            snap_q     <= snap_d;
            reg_idx_q  <= reg_idx_d;
            dump_reg_q <= dump_reg_d;
            byte_q     <= byte_d;
            hdr_q      <= hdr_d;
        end
    end

    assign frame_end = (cnt_q == 4'd9) && (tmr_q == TMR_MAX);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        snap_d     = snap_q;
        reg_idx_d  = reg_idx_q;
        dump_reg_d = dump_reg_q;
        byte_d     = byte_q;
        hdr_d      = hdr_q;

        case (byte_q)
            2'd0:    nxt_byte = snap_q[23:16];
            2'd1:    nxt_byte = snap_q[15:8];
            default: nxt_byte = snap_q[7:0];
        endcase

        // Byte engine: slot 0 start, 1..8 data LSB first, 9 stop
        if (state_q == S_HDR || state_q == S_SEND) begin
            if (tmr_q == TMR_MAX) begin
                tmr_d = '0;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q < 4'd8) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    tx_d = 1'b1;
                end
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_HDR;
                    shift_d   = HDR_BYTE;
                    tx_d      = 1'b0;
                    tmr_d     = '0;
                    cnt_d     = '0;
                    reg_idx_d = '0;
                    byte_d    = '0;
                    hdr_d     = 1'b1;
                end
            end
            S_HDR: state_d = S_SEND;
            S_FETCH: begin
                dump_reg_d = reg_idx_q;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                snap_d  = dump_dat;
                shift_d = dump_dat[31:24];
                tx_d    = 1'b0;
                tmr_d   = '0;
                cnt_d   = '0;
                byte_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (frame_end) begin
                    tx_d  = 1'b1;
                    tmr_d = '0;
                    cnt_d = '0;
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = S_FETCH;
                    end else if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = nxt_byte;
                        tx_d    = 1'b0;
                    end else if (reg_idx_q != 5'd31) begin
                        reg_idx_d = reg_idx_q + 5'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign dump_reg = dump_reg_q;
    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump_tx.sv
// tb_reg_dump_tx: compares whole UART waveforms of reg_dump_tx against
// a waveform rebuilt from the register contents and the frame rules.
module tb_reg_dump_tx;
    localparam int CPB  = 4;
    localparam int CPB2 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [4:0]  dump_reg, dump_reg2;
    logic [31:0] dump_dat, dump_dat2;
    logic        tx, tx2, busy, busy2, done, done2;
    logic [31:0] rf [32];
    logic [31:0] rf2 [32];

    assign dump_dat  = rf[dump_reg];
    assign dump_dat2 = rf2[dump_reg2];

    reg_dump_tx #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dump_reg(dump_reg),
        .dump_dat(dump_dat), .tx(tx), .busy(busy), .done(done)
    );

    reg_dump_tx #(.CLKS_PER_BIT(CPB2), .HDR_BYTE(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dump_reg(dump_reg2),
        .dump_dat(dump_dat2), .tx(tx2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } vec_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic       tr [$];
    logic       wave [$];
    logic [7:0] expb [$];
    logic [7:0] rx [$];
    int         rxpos [$];
    int         done_k, done_cnt, busy_err;
    vec_t       tbl [8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start2 = v;
        else start = v;
    endtask

    // Expected byte stream: header then every word, most significant byte first
    task automatic build_exp(input bit sel);
        logic [31:0] w;
        expb.delete();
        expb.push_back(8'hA5);
        for (int r = 0; r < 32; r++) begin
            w = sel ? rf2[r] : rf[r];
            for (int b = 3; b >= 0; b--) expb.push_back(w[8*b +: 8]);
        end
    endtask

    // Expected line level per cycle, starting at the first start bit
    task automatic build_wave(input int cpb);
        logic v;
        wave.delete();
        for (int i = 0; i < expb.size(); i++) begin
            if (i > 0 && (i - 1) % 4 == 0) begin
                wave.push_back(1'b1);
                wave.push_back(1'b1);
            end
            for (int s = 0; s < 10; s++) begin
                if (s == 0) v = 1'b0;
                else if (s == 9) v = 1'b1;
                else v = expb[i][s-1];
                for (int c = 0; c < cpb; c++) wave.push_back(v);
            end
        end
    endtask

    task automatic do_dump(input bit sel, input int mid_start,
                           input bit start_done, input bit hz);
        logic t, b, d;
        bit   armed;
        armed = hz;
        tr.delete();
        done_k = -1;
        done_cnt = 0;
        busy_err = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        tr.push_back(1'b1);
        for (int k = 1; k < 8000; k++) begin
            t = sel ? tx2 : tx;
            b = sel ? busy2 : busy;
            d = sel ? done2 : done;
            tr.push_back(t);
            if (d) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k < 0 && !b) busy_err++;
            if (done_k >= 0 && b) busy_err++;
            if (k == mid_start) set_start(sel, 1'b1);
            if (k == mid_start + 1) set_start(sel, 1'b0);
            if (start_done && k == done_k) set_start(sel, 1'b1);
            if (start_done && done_k >= 0 && k == done_k + 1) set_start(sel, 1'b0);
            if (armed && !sel && dump_reg == 5'd5 && t == 1'b0) begin
                rf[5] = 32'hDEADBEEF;
                armed = 0;
            end
            if (done_k >= 0 && k == done_k + 4) break;
            @(negedge clk);
        end
    endtask

    task automatic decode(input int cpb);
        logic [7:0] by;
        int p;
        rx.delete();
        rxpos.delete();
        p = 1;
        while (p + 10 * cpb <= tr.size()) begin
            if (tr[p] == 1'b0) begin
                for (int j = 0; j < 8; j++) by[j] = tr[p + (j + 1) * cpb + cpb / 2];
                rx.push_back(by);
                rxpos.push_back(p);
                p += 10 * cpb;
            end else begin
                p++;
            end
        end
    endtask

    task automatic check_dump(input bit sel, input string tag);
        int cpb, mism, nbad;
        cpb = sel ? CPB2 : CPB;
        build_wave(cpb);
        chk({tag, " done_seen"}, done_k >= 0, 1);
        chk({tag, " done_count"}, done_cnt, 1);
        chk({tag, " done_cycle"}, done_k - 1, 1290 * cpb + 64);
        chk({tag, " busy_window"}, busy_err, 0);
        mism = -1;
        for (int i = 0; i < wave.size(); i++) begin
            if (i + 1 >= tr.size() || tr[i+1] !== wave[i]) begin
                mism = i;
                break;
            end
        end
        chk({tag, " wave_first_mismatch"}, mism, -1);
        decode(cpb);
        chk({tag, " byte_count"}, rx.size(), 129);
        nbad = 0;
        for (int i = 0; i < 129; i++)
            if (i >= rx.size() || rx[i] !== expb[i]) nbad++;
        chk({tag, " bad_bytes"}, nbad, 0);
    endtask

    initial begin
        tbl[0] = '{0, 8'hA5};
        tbl[1] = '{1, 8'h00};
        tbl[2] = '{64, 8'h00};
        tbl[3] = '{65, 8'h00};
        tbl[4] = '{66, 8'h00};
        tbl[5] = '{67, 8'hAB};
        tbl[6] = '{68, 8'hCD};
        tbl[7] = '{128, 8'h00};

        for (int r = 0; r < 32; r++) begin
            rf[r] = '0;
            rf2[r] = $urandom;
        end
        rf[16] = 32'h0000ABCD;

        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dump_reg", dump_reg, 0);
        chk("reset tx2", tx2, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic dump
        build_exp(1'b0);
        do_dump(1'b0, -1, 1'b0, 1'b0);
        check_dump(1'b0, "basic");
        for (int i = 0; i < 8; i++)
            chk($sformatf("basic byte%0d", tbl[i].idx),
                tbl[i].idx < rx.size() ? rx[tbl[i].idx] : 8'hxx, tbl[i].val);
        chk("basic dump_reg_hold", dump_reg, 31);
        chk("basic first_start_bit", tr[1], 0);

        // Pattern dump with gap and back-to-back timing
        for (int r = 0; r < 32; r++) rf[r] = {4{8'(r) + 8'h10}};
        build_exp(1'b0);
        do_dump(1'b0, -1, 1'b0, 1'b0);
        check_dump(1'b0, "pattern");
        if (rxpos.size() > 5) begin
            chk("pattern word_gap", rxpos[5] - (rxpos[4] + 10 * CPB), 2);
            chk("pattern b2b_gap", rxpos[2] - (rxpos[1] + 10 * CPB), 0);
        end else begin
            chk("pattern frames", rxpos.size(), 129);
        end

        // Snapshot hazard: reg5 rewritten right after its load
        for (int r = 0; r < 32; r++) rf[r] = '0;
        rf[5] = 32'h11223344;
        build_exp(1'b0);
        do_dump(1'b0, -1, 1'b0, 1'b1);
        check_dump(1'b0, "hazard1");
        chk("hazard1 reg5", rx.size() > 24 ? {rx[21], rx[22], rx[23], rx[24]} : 0,
            32'h11223344);
        build_exp(1'b0);
        do_dump(1'b0, -1, 1'b0, 1'b0);
        check_dump(1'b0, "hazard2");
        chk("hazard2 reg5", rx.size() > 24 ? {rx[21], rx[22], rx[23], rx[24]} : 0,
            32'hDEADBEEF);

        // Start pulses while busy and in the done cycle
        for (int r = 0; r < 32; r++) rf[r] = $urandom;
        build_exp(1'b0);
        do_dump(1'b0, 1000, 1'b1, 1'b0);
        check_dump(1'b0, "busy_start");
        chk("busy_start idle_after", busy, 0);

        // Reset during bit 4 of byte 40
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40 * 10 * CPB + 2 * ((40 + 3) / 4) + 4 * CPB) @(negedge clk);
        chk("pre_reset dump_reg", dump_reg, 9);
        chk("pre_reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset tx", tx, 1);
        chk("async_reset busy", busy, 0);
        chk("async_reset dump_reg", dump_reg, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset tx", tx, 1);
        build_exp(1'b0);
        do_dump(1'b0, -1, 1'b0, 1'b0);
        check_dump(1'b0, "after_reset");

        // Random contents and a random ignored start
        for (int n = 0; n < 2; n++) begin
            for (int r = 0; r < 32; r++) rf[r] = $urandom;
            build_exp(1'b0);
            do_dump(1'b0, int'($urandom_range(2, 5000)), 1'b0, 1'b0);
            check_dump(1'b0, $sformatf("random%0d", n));
        end

        // Two-cycle bits on the second instance
        chk("cpb2 idle_tx", tx2, 1);
        build_exp(1'b1);
        do_dump(1'b1, -1, 1'b0, 1'b0);
        check_dump(1'b1, "cpb2");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
